// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic light controller.
//   - state_e   : controller state encoding (also driven on the phase output)
//   - LAMP_*    : bit positions of each lamp inside a lamp_t vector
//   - is_ped_phase(): true while pedestrians own the crossing
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_GA     = 3'd1,
        ST_YA     = 3'd2,
        ST_GB     = 3'd3,
        ST_YB     = 3'd4,
        ST_WALK   = 3'd5,
        ST_WCLR   = 3'd6,
        ST_FLASH  = 3'd7
    } state_e;

    localparam int LAMP_GA = 0;
    localparam int LAMP_YA = 1;
    localparam int LAMP_RA = 2;
    localparam int LAMP_GB = 3;
    localparam int LAMP_YB = 4;
    localparam int LAMP_RB = 5;
    localparam int LAMP_GW = 6;
    localparam int LAMP_RW = 7;
    localparam int LAMP_W  = 8;

    typedef logic [LAMP_W-1:0] lamp_t;

    function automatic logic is_ped_phase(state_e s);
        return (s == ST_WALK) || (s == ST_WCLR);
    endfunction

endpackage

// File: rtl/tick_div.sv
// tick_div: free-running clock divider producing a one-cycle tick.
// Counts 0..TICK_DIV-1 and wraps; tick is high while the count sits at
// TICK_DIV-1. A restart forces the count back to 0 on the next edge so a
// new phase always begins on a whole-second boundary.
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset (count -> 0)
//   restart in   clear the count on the next edge
//   count   out  current divider value
//   tick    out  high on the last cycle of each second
module tick_div #(
    parameter int TICK_DIV = 1000,
    parameter int CW       = $clog2(TICK_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restart,
    output logic [CW-1:0] count,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + CW'(1);
        if (restart || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tick  = (count_q == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road intersection controller with pedestrian
// walk phase and a maintenance all-red flash mode.
// Build option: define PED_BUTTON_EN to make the walk phase on demand
// (latched ped_req); without it every cycle of the sequence includes WALK
// and ped_req is ignored.
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst_n    in   synchronous active-low reset
//   ped_req  in   pedestrian request level
//   maint    in   maintenance flash request (level)
//   ga ya ra out  road A lamps
//   gb yb rb out  road B lamps
//   gw rw    out  walk lamps
//   phase    out  current state (traffic_pkg::state_e encoding)
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int TW       = 4,
    parameter int T_GA     = 3,
    parameter int T_YA     = 2,
    parameter int T_GB     = 3,
    parameter int T_YB     = 1,
    parameter int T_WALK   = 2,
    parameter int T_WCLR   = 2,
    parameter int T_ALLRED = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       maint,
    output logic       ga,
    output logic       ya,
    output logic       ra,
    output logic       gb,
    output logic       yb,
    output logic       rb,
    output logic       gw,
    output logic       rw,
    output logic [2:0] phase
);

    localparam int CW = $clog2(TICK_DIV);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] div;
    logic          tick;
    logic          restart;
    logic          walk_wanted;
    lamp_t         lamps;

    tick_div #(
        .TICK_DIV (TICK_DIV),
        .CW       (CW)
    ) u_tick_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .count   (div),
        .tick    (tick)
    );

    // Timer holds remaining whole seconds after the current one.
    function automatic logic [TW-1:0] load_val(state_e s);
        case (s)
            ST_ALLRED: return TW'(T_ALLRED - 1);
            ST_GA:     return TW'(T_GA - 1);
            ST_YA:     return TW'(T_YA - 1);
            ST_GB:     return TW'(T_GB - 1);
            ST_YB:     return TW'(T_YB - 1);
            ST_WALK:   return TW'(T_WALK - 1);
            ST_WCLR:   return TW'(T_WCLR - 1);
            default:   return '0;
        endcase
    endfunction

    function automatic state_e succ(state_e s, logic walk);
        case (s)
            ST_ALLRED: return ST_GA;
            ST_GA:     return ST_YA;
            ST_YA:     return ST_GB;
            ST_GB:     return ST_YB;
            ST_YB:     return walk ? ST_WALK : ST_GA;
            ST_WALK:   return ST_WCLR;
            ST_WCLR:   return ST_GA;
            default:   return ST_ALLRED;
        endcase
    endfunction

    // Next state / timer. maint overrides any expiry; leaving FLASH is
    // immediate once maint drops.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (maint) begin
            state_d = ST_FLASH;
        end else if (state_q == ST_FLASH) begin
            state_d = ST_ALLRED;
        end else if (tick) begin
            if (timer_q == '0) begin
                state_d = succ(state_q, walk_wanted);
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
        if (state_d != state_q) begin
            timer_d = load_val(state_d);
        end
        restart = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ALLRED;
            timer_q <= TW'(T_ALLRED - 1);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

`ifdef PED_BUTTON_EN
    logic ped_pend_q, ped_pend_d;

    // Entering WALK serves the request, so the clear wins over a request
    // arriving on that same edge.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if ((state_d == ST_WALK) && (state_q != ST_WALK)) begin
            ped_pend_d = 1'b0;
        end else if (ped_req && !is_ped_phase(state_q)) begin
            ped_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end

    assign walk_wanted = ped_pend_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign walk_wanted    = 1'b1;
`endif

    // Lamp decode from registered state and divider only.
    logic flash_on;
    logic clr_on;
    assign flash_on = (div < CW'(TICK_DIV / 2));
    // 2 Hz: on during the first quarter of each half second.
    assign clr_on   = (div < CW'(TICK_DIV / 4)) ||
                      ((div >= CW'(TICK_DIV / 2)) && (div < CW'(3 * TICK_DIV / 4)));

    always_comb begin
        lamps = '0;
        case (state_q)
            ST_ALLRED: begin
                lamps[LAMP_RA] = 1'b1;
                lamps[LAMP_RB] = 1'b1;
                lamps[LAMP_RW] = 1'b1;
            end
            ST_GA: begin
                lamps[LAMP_GA] = 1'b1;
                lamps[LAMP_RB] = 1'b1;
                lamps[LAMP_RW] = 1'b1;
            end
            ST_YA: begin
                lamps[LAMP_YA] = 1'b1;
                lamps[LAMP_RB] = 1'b1;
                lamps[LAMP_RW] = 1'b1;
            end
            ST_GB: begin
                lamps[LAMP_RA] = 1'b1;
                lamps[LAMP_GB] = 1'b1;
                lamps[LAMP_RW] = 1'b1;
            end
            ST_YB: begin
                lamps[LAMP_RA] = 1'b1;
                lamps[LAMP_YB] = 1'b1;
                lamps[LAMP_RW] = 1'b1;
            end
            ST_WALK: begin
                lamps[LAMP_RA] = 1'b1;
                lamps[LAMP_RB] = 1'b1;
                lamps[LAMP_GW] = 1'b1;
            end
            ST_WCLR: begin
                lamps[LAMP_RA] = 1'b1;
                lamps[LAMP_RB] = 1'b1;
                lamps[LAMP_RW] = clr_on;
            end
            ST_FLASH: begin
                lamps[LAMP_RA] = flash_on;
                lamps[LAMP_RB] = flash_on;
                lamps[LAMP_RW] = flash_on;
            end
            default: begin
                lamps[LAMP_RA] = 1'b1;
                lamps[LAMP_RB] = 1'b1;
                lamps[LAMP_RW] = 1'b1;
            end
        endcase
    end

    assign ga    = lamps[LAMP_GA];
    assign ya    = lamps[LAMP_YA];
    assign ra    = lamps[LAMP_RA];
    assign gb    = lamps[LAMP_GB];
    assign yb    = lamps[LAMP_YB];
    assign rb    = lamps[LAMP_RB];
    assign gw    = lamps[LAMP_GW];
    assign rw    = lamps[LAMP_RW];
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed + randomized stimulus against a
// phase/elapsed-cycle reference model of the intersection controller.
// Works with or without PED_BUTTON_EN defined.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n, ped_req, maint;
    logic       ga, ya, ra, gb, yb, rb, gw, rw;
    logic [2:0] phase;

    always #5 clk = ~clk;

    traffic_light_ctrl #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ped_req (ped_req),
        .maint   (maint),
        .ga      (ga),
        .ya      (ya),
        .ra      (ra),
        .gb      (gb),
        .yb      (yb),
        .rb      (rb),
        .gw      (gw),
        .rw      (rw),
        .phase   (phase)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: which phase we are in and how many cycles it has lasted.
    state_e m_ph   = ST_ALLRED;
    state_e m_prev = ST_ALLRED;
    int     m_age  = 0;
`ifdef PED_BUTTON_EN
    bit     m_pend = 0;
`endif

    function automatic int m_secs(state_e s);
        case (s)
            ST_ALLRED: return 1;
            ST_GA:     return 3;
            ST_YA:     return 2;
            ST_GB:     return 3;
            ST_YB:     return 1;
            ST_WALK:   return 2;
            ST_WCLR:   return 2;
            default:   return 1;
        endcase
    endfunction

    function automatic state_e m_succ(state_e s);
        case (s)
            ST_ALLRED: return ST_GA;
            ST_GA:     return ST_YA;
            ST_YA:     return ST_GB;
            ST_GB:     return ST_YB;
`ifdef PED_BUTTON_EN
            ST_YB:     return m_pend ? ST_WALK : ST_GA;
`else
            ST_YB:     return ST_WALK;
`endif
            ST_WALK:   return ST_WCLR;
            default:   return ST_GA;
        endcase
    endfunction

    function automatic lamp_t m_lamps(state_e ph, int age);
        lamp_t l;
        logic  on;
        l = '0;
        case (ph)
            ST_ALLRED: begin l[LAMP_RA] = 1; l[LAMP_RB] = 1; l[LAMP_RW] = 1; end
            ST_GA:     begin l[LAMP_GA] = 1; l[LAMP_RB] = 1; l[LAMP_RW] = 1; end
            ST_YA:     begin l[LAMP_YA] = 1; l[LAMP_RB] = 1; l[LAMP_RW] = 1; end
            ST_GB:     begin l[LAMP_RA] = 1; l[LAMP_GB] = 1; l[LAMP_RW] = 1; end
            ST_YB:     begin l[LAMP_RA] = 1; l[LAMP_YB] = 1; l[LAMP_RW] = 1; end
            ST_WALK:   begin l[LAMP_RA] = 1; l[LAMP_RB] = 1; l[LAMP_GW] = 1; end
            ST_WCLR: begin
                l[LAMP_RA] = 1;
                l[LAMP_RB] = 1;
                l[LAMP_RW] = ((age % (TD / 2)) < (TD / 4));
            end
            default: begin
                on = ((age % TD) < (TD / 2));
                l[LAMP_RA] = on;
                l[LAMP_RB] = on;
                l[LAMP_RW] = on;
            end
        endcase
        return l;
    endfunction

    task automatic model_step();
        state_e nxt;
        if (!rst_n) begin
            m_ph  = ST_ALLRED;
            m_age = 0;
`ifdef PED_BUTTON_EN
            m_pend = 0;
`endif
            return;
        end
        if (maint)                                nxt = ST_FLASH;
        else if (m_ph == ST_FLASH)                nxt = ST_ALLRED;
        else if (m_age == m_secs(m_ph) * TD - 1)  nxt = m_succ(m_ph);
        else                                      nxt = m_ph;
`ifdef PED_BUTTON_EN
        if (nxt == ST_WALK && m_ph != ST_WALK)
            m_pend = 0;
        else if (ped_req && m_ph != ST_WALK && m_ph != ST_WCLR)
            m_pend = 1;
`endif
        m_age = (nxt == m_ph) ? m_age + 1 : 0;
        m_ph  = nxt;
    endtask

    task automatic compare();
        lamp_t obs;
        obs = '0;
        obs[LAMP_GA] = ga; obs[LAMP_YA] = ya; obs[LAMP_RA] = ra;
        obs[LAMP_GB] = gb; obs[LAMP_YB] = yb; obs[LAMP_RB] = rb;
        obs[LAMP_GW] = gw; obs[LAMP_RW] = rw;
        check("lamps", 32'(obs), 32'(m_lamps(m_ph, m_age)));
        check("phase", 32'(phase), 32'(m_ph));
        check("walk_safe", 32'(gw & ~(ra & rb)), 32'd0);
        if (m_ph != m_prev)
            $display("t=%0t phase %s -> %s lamps=%b", $time, m_prev.name(), m_ph.name(), obs);
        m_prev = m_ph;
    endtask

    task automatic step(input logic r, input logic p, input logic m);
        rst_n   = r;
        ped_req = p;
        maint   = m;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic wait_phase(input state_e target, input string tag);
        int n;
        n = 0;
        while (m_ph != target && n < 200) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        if (m_ph != target) check({"wait_", tag}, 32'(phase), 32'(target));
    endtask

    initial begin
        logic mlvl;
        int   n;

        // Reset, then a plain cycle with no requests.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run(44);

        // One-cycle pedestrian pulse during GA.
        wait_phase(ST_GA, "ga1");
        step(1'b1, 1'b1, 1'b0);
        run(60);

        // Request held only while WALK/WCLR is active.
        wait_phase(ST_GA, "ga2");
        step(1'b1, 1'b1, 1'b0);
        wait_phase(ST_WALK, "walk1");
        n = 0;
        while ((m_ph == ST_WALK || m_ph == ST_WCLR) && n < 100) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        run(50);

        // Maintenance mid-GB, then release.
        wait_phase(ST_GB, "gb");
        run(3);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b1);
        run(20);

        // Reset mid-WALK with maint asserted.
        wait_phase(ST_GA, "ga3");
        step(1'b1, 1'b1, 1'b0);
        wait_phase(ST_WALK, "walk2");
        run(3);
        step(1'b0, 1'b1, 1'b1);
        run(40);

        // Randomized traffic.
        mlvl = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 59) == 0) mlvl = ~mlvl;
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 11) == 0), mlvl);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
